// File: rtl/adc_test_unit.sv
// Preamp + dual-channel ADC bring-up: programs the preamp gain once, then loops conversions
// and shows the top 8 bits of channel A on the LEDs (channel B with ADC_LED_CHAN_B_EN).
module adc_test_unit #(
  parameter int unsigned CLK_DIV  = 1,
  parameter logic [7:0]  AMP_GAIN = 8'h11
) (
  input  logic       clk,
  input  logic       reset,
  output logic       spi_sck,
  output logic       amp_cs,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       ad_conv,
  output logic       spi_ss_b,
  output logic       dac_cs,
  output logic       sf_ce0,
  output logic       fpga_init_b,
  output logic       amp_shdn,
  output logic       dac_clr,
  output logic [7:0] led
);

  localparam int unsigned CntW = $clog2(2 * CLK_DIV + 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GapEnd  = CntW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    StAmpLoad,
    StAmpShift,
    StAmpGap,
    StConv,
    StRead,
    StUpdate
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      bit_q, bit_d;
  logic            sck_q, sck_d;
  logic            cs_q, cs_d;
  logic            mosi_q, mosi_d;
  logic            conv_q, conv_d;
  logic [7:0]      amp_sh_q, amp_sh_d;
  logic [33:0]     sh_q, sh_d;
  logic [13:0]     cha_q, cha_d;
  logic [13:0]     chb_q, chb_d;
  logic            half_tick;

  // Park every other device on the shared bus.
  assign spi_ss_b    = 1'b1;
  assign dac_cs      = 1'b1;
  assign sf_ce0      = 1'b1;
  assign fpga_init_b = 1'b1;
  assign amp_shdn    = 1'b0;
  assign dac_clr     = 1'b1;

  assign spi_sck  = sck_q;
  assign amp_cs   = cs_q;
  assign spi_mosi = mosi_q;
  assign ad_conv  = conv_q;

`ifdef ADC_LED_CHAN_B_EN
  assign led = chb_q[13:6];
`else
  assign led = cha_q[13:6];
`endif

  logic unused_bits;
  assign unused_bits = ^{amp_sh_q[7], sh_q[33], cha_q, chb_q};

  assign half_tick = (cnt_q == HalfEnd);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sck_d    = sck_q;
    cs_d     = cs_q;
    mosi_d   = mosi_q;
    conv_d   = conv_q;
    amp_sh_d = amp_sh_q;
    sh_d     = sh_q;
    cha_d    = cha_q;
    chb_d    = chb_q;

    unique case (state_q)
      StAmpLoad: begin
        amp_sh_d = AMP_GAIN;
        cs_d     = 1'b0;
        mosi_d   = AMP_GAIN[7];
        cnt_d    = '0;
        bit_d    = '0;
        sck_d    = 1'b0;
        state_d  = StAmpShift;
      end
      StAmpShift: begin
        if (half_tick) begin
          cnt_d = '0;
          sck_d = ~sck_q;
          // Falling edge: present the next gain bit.
          if (sck_q) begin
            amp_sh_d = {amp_sh_q[6:0], 1'b0};
            mosi_d   = amp_sh_q[6];
            bit_d    = bit_q + 6'd1;
            if (bit_q == 6'd7) begin
              cs_d    = 1'b1;
              mosi_d  = 1'b0;
              bit_d   = '0;
              state_d = StAmpGap;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAmpGap: begin
        if (cnt_q == GapEnd) begin
          cnt_d   = '0;
          conv_d  = 1'b1;
          state_d = StConv;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StConv: begin
        if (cnt_q == GapEnd) begin
          cnt_d   = '0;
          bit_d   = '0;
          sck_d   = 1'b0;
          conv_d  = 1'b0;
          state_d = StRead;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRead: begin
        if (half_tick) begin
          cnt_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            sh_d = {sh_q[32:0], spi_miso};
          end else begin
            if (bit_q != 6'd34) bit_d = bit_q + 6'd1;
            if (bit_q == 6'd33) state_d = StUpdate;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StUpdate: begin
        cha_d   = sh_q[31:18];
        chb_d   = sh_q[15:2];
        cnt_d   = '0;
        conv_d  = 1'b1;
        state_d = StConv;
      end
      default: begin
        state_d = StAmpLoad;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StAmpLoad;
      cnt_q    <= '0;
      bit_q    <= '0;
      sck_q    <= 1'b0;
      cs_q     <= 1'b1;
      mosi_q   <= 1'b0;
      conv_q   <= 1'b0;
      amp_sh_q <= '0;
      sh_q     <= '0;
      cha_q    <= '0;
      chb_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sck_q    <= sck_d;
      cs_q     <= cs_d;
      mosi_q   <= mosi_d;
      conv_q   <= conv_d;
      amp_sh_q <= amp_sh_d;
      sh_q     <= sh_d;
      cha_q    <= cha_d;
      chb_q    <= chb_d;
    end
  end

endmodule

// File: tb/tb_adc_test_unit.sv
// Self-checking bench for adc_test_unit: behavioural ADC/preamp model with random sample words.
module tb_adc_test_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sck, amp_cs, spi_mosi, spi_miso, ad_conv;
  logic       spi_ss_b, dac_cs, sf_ce0, fpga_init_b, amp_shdn, dac_clr;
  logic [7:0] led;

  int          errors = 0;
  int          checks = 0;
  logic [33:0] word;
  logic [33:0] cap;
  logic [7:0]  amp_bits;
  int          rises;
  int          tcnt;
  bit          toggle_mode;
  logic        prev_sck;
  logic        prev_mosi;

  adc_test_unit dut (
    .clk        (clk),
    .reset      (reset),
    .spi_sck    (spi_sck),
    .amp_cs     (amp_cs),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .ad_conv    (ad_conv),
    .spi_ss_b   (spi_ss_b),
    .dac_cs     (dac_cs),
    .sf_ce0     (sf_ce0),
    .fpga_init_b(fpga_init_b),
    .amp_shdn   (amp_shdn),
    .dac_clr    (dac_clr),
    .led        (led)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the ADC/preamp model reacts to SCK rising edges seen on this edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (spi_sck === 1'b1 && prev_sck === 1'b0) begin
      cap      = {cap[32:0], spi_miso};
      amp_bits = {amp_bits[6:0], prev_mosi};
      rises++;
      if (!toggle_mode) spi_miso = (rises < 34) ? word[33 - rises] : 1'b0;
    end
    if (toggle_mode) begin
      tcnt++;
      if (tcnt == 5) begin
        tcnt     = 0;
        spi_miso = ~spi_miso;
      end
    end
    prev_sck  = spi_sck;
    prev_mosi = spi_mosi;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    check("rst1_sck", spi_sck, 1'b0);
    check("rst1_cs", amp_cs, 1'b1);
    check("rst1_conv", ad_conv, 1'b0);
    check("rst1_led", led, 8'h00);
    repeat (11) step();
    check("rst12_sck", spi_sck, 1'b0);
    check("rst12_cs", amp_cs, 1'b1);
    check("rst12_mosi", spi_mosi, 1'b0);
    check("rst12_conv", ad_conv, 1'b0);
    check("rst12_led", led, 8'h00);
    check("rst_consts", {spi_ss_b, dac_cs, sf_ce0, fpga_init_b, amp_shdn, dac_clr}, 6'b111101);
    reset       = 1'b0;
    toggle_mode = 1'b0;
    spi_miso    = 1'b0;
    word        = '0;
  endtask

  // Preamp programming, then the gap up to the first conversion pulse.
  task automatic amp_phase();
    int  n;
    int  cs_low;
    bit  overlap;
    rises    = 0;
    amp_bits = '0;
    n        = 0;
    while (amp_cs !== 1'b0 && n < 10) begin
      step();
      n++;
    end
    check("amp_cs_seen", amp_cs, 1'b0);
    cs_low  = 0;
    overlap = 1'b0;
    n       = 0;
    while (amp_cs === 1'b0 && n < 60) begin
      cs_low++;
      if (ad_conv !== 1'b0) overlap = 1'b1;
      step();
      n++;
    end
    check("amp_cs_low_cycles", cs_low, 16);
    check("amp_sck_periods", rises, 8);
    check("amp_word", amp_bits, 8'h11);
    check("amp_conv_overlap", overlap, 1'b0);
    n = 0;
    while (ad_conv !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("amp_gap_cycles", n, 2);
    check("led_before_first_update", led, 8'h00);
  endtask

  // Entered on the cycle ad_conv rises; returns on the next rise.
  task automatic run_frame(input logic [33:0] w, input bit tog);
    int         cyc;
    int         conv_w;
    bit         sck_bad;
    bit         got;
    logic       prev_conv;
    logic [7:0] exp_led;
    word        = w;
    toggle_mode = tog;
    tcnt        = 0;
    cap         = '0;
    rises       = 0;
    if (!tog) spi_miso = w[33];
    cyc       = 0;
    conv_w    = 1;
    sck_bad   = 1'b0;
    got       = 1'b0;
    prev_conv = 1'b1;
    while (!got && cyc < 200) begin
      step();
      cyc++;
      if (ad_conv === 1'b1 && prev_conv !== 1'b1) begin
        got = 1'b1;
      end else if (ad_conv === 1'b1) begin
        conv_w++;
        if (spi_sck !== 1'b0) sck_bad = 1'b1;
      end
      if (amp_cs !== 1'b1) sck_bad = 1'b1;
      prev_conv = ad_conv;
    end
`ifdef ADC_LED_CHAN_B_EN
    exp_led = cap[15:8];
`else
    exp_led = cap[31:24];
`endif
    check("frame_seen", got, 1'b1);
    check("conv_width", conv_w, 2);
    check("conv_sck_cs_ok", sck_bad, 1'b0);
    check("read_rises", rises, 34);
    check("loop_period", cyc, 71);
    check("led_value", led, exp_led);
  endtask

  initial begin
    logic [63:0] r;
    logic [33:0] pat5;
    reset       = 1'b1;
    spi_miso    = 1'b0;
    word        = '0;
    cap         = '0;
    amp_bits    = '0;
    rises       = 0;
    tcnt        = 0;
    toggle_mode = 1'b0;
    prev_sck    = 1'b0;
    prev_mosi   = 1'b0;
    pat5        = {2'b10, 14'h1555, 2'b01, 14'h2AAA, 2'b11};

    do_reset();
    amp_phase();
    run_frame(34'h3_FFFF_FFFF, 1'b0);
    run_frame(34'h0, 1'b0);
    run_frame(pat5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      r = {$urandom(), $urandom()};
      run_frame(r[33:0], 1'b0);
    end
    run_frame(34'h0, 1'b1);

    // Reset again partway through a read.
    r = {$urandom(), $urandom()};
    word        = r[33:0];
    toggle_mode = 1'b0;
    repeat ($urandom_range(10, 60)) step();
    do_reset();
    prev_sck = 1'b0;
    amp_phase();
    for (int i = 0; i < 3; i++) begin
      r = {$urandom(), $urandom()};
      run_frame(r[33:0], 1'b0);
    end
    run_frame(34'h0, 1'b1);
    run_frame(34'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
